// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring radix-2 unsigned divider with start/done handshake.
// Results (quot/rem/div_by_zero) are loaded from the working registers one cycle
// after the FSM enters DONE, which is also when the done pulse is driven.
module seq_div #(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_by_zero
);

    localparam int unsigned W     = DATAWIDTH;
    localparam int unsigned CNT_W = $clog2(DATAWIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Working dividend; quotient bits shift into its LSB as dividend bits leave the MSB.
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    // Partial remainder; always < divisor between steps, so W bits suffice for storage.
    logic [W-1:0]   p_q, p_d;
    logic           dz_q, dz_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [W-1:0]   quot_q, quot_d;
    logic [W-1:0]   rem_q, rem_d;
    logic           dbz_q, dbz_d;

    logic [W:0]     p_shift;
    logic           q_bit;

    // Next-state, datapath step and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        p_d     = p_q;
        dz_d    = dz_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        p_shift = {p_q, dvd_q[W-1]};
        q_bit   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (b != '0) begin
                        dvd_d   = a;
                        dvs_d   = b;
                        p_d     = '0;
                        dz_d    = 1'b0;
                        cnt_d   = CNT_W'(W);
                        state_d = S_RUN;
                    end else begin
                        dvd_d   = '1;
                        p_d     = a;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (p_shift >= {1'b0, dvs_q}) begin
                    p_d   = W'(p_shift - {1'b0, dvs_q});
                    q_bit = 1'b1;
                end else begin
                    p_d   = W'(p_shift);
                end
                dvd_d = {dvd_q[W-2:0], q_bit};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_q == S_DONE);
        if (state_q == S_DONE) begin
            quot_d = dvd_q;
            rem_d  = p_q;
            dbz_d  = dz_q;
        end
    end

    // State, working and output registers with asynchronous clear.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            p_q     <= '0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            p_q     <= p_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quot        = quot_q;
    assign rem         = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed, table-driven checks of the seq_div handshake, latency and results.
module tb_seq_div;

    localparam int unsigned W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic         Clk;
    logic         Rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_div #(.DATAWIDTH(W)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Returns the number of edges until done is seen (0 if it never arrives).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic do_div(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int elat);
        int lat;
        a = ia; b = ib; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done(lat);
        check({name, ".latency"}, 32'(lat), 32'(elat));
        check({name, ".quot"}, 32'(quot), 32'(eq));
        check({name, ".rem"}, 32'(rem), 32'(er));
        check({name, ".dbz"}, 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        vec_t vecs[7];
        int   n;
        int   lat;
        int   busy_cnt;

        vecs[0] = '{a: 16'd9,      b: 16'd1,      q: 16'd9,      r: 16'd0, dz: 1'b0};
        vecs[1] = '{a: 16'd1,      b: 16'd9,      q: 16'd0,      r: 16'd1, dz: 1'b0};
        vecs[2] = '{a: 16'hFFFF,   b: 16'd1,      q: 16'hFFFF,   r: 16'd0, dz: 1'b0};
        vecs[3] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'd1,      r: 16'd0, dz: 1'b0};
        vecs[4] = '{a: 16'd0,      b: 16'd5,      q: 16'd0,      r: 16'd0, dz: 1'b0};
        vecs[5] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2, dz: 1'b0};
        vecs[6] = '{a: 16'd1000,   b: 16'd10,     q: 16'd100,    r: 16'd0, dz: 1'b0};
        n = 7;

        Rst = 1'b0; start = 1'b0; a = '0; b = '0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.quot", 32'(quot), 32'd0);
        check("rst.rem", 32'(rem), 32'd0);
        check("rst.dbz", 32'(div_by_zero), 32'd0);

        // 100/7 with busy-length and latency measurement, then hold
        a = 16'd100; b = 16'd7; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge Clk); #1;
            if (done) begin
                lat = i;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("d100_7.latency", 32'(lat), 32'd17);
        check("d100_7.busy_cycles", 32'(busy_cnt), 32'd16);
        check("d100_7.quot", 32'(quot), 32'd14);
        check("d100_7.rem", 32'(rem), 32'd2);
        check("d100_7.dbz", 32'(div_by_zero), 32'd0);
        repeat (5) @(posedge Clk);
        #1;
        check("d100_7.hold_quot", 32'(quot), 32'd14);
        check("d100_7.hold_rem", 32'(rem), 32'd2);
        check("d100_7.hold_done", 32'(done), 32'd0);

        // Back-to-back sweep with start held high; each result appears as the next divide begins
        a = vecs[0].a; b = vecs[0].b; start = 1'b1;
        @(posedge Clk); #1;
        for (int k = 0; k < n; k++) begin
            if (k + 1 < n) begin
                a = vecs[k+1].a; b = vecs[k+1].b;
            end else begin
                start = 1'b0;
            end
            repeat (17) @(posedge Clk);
            #1;
            check($sformatf("sweep%0d.done", k), 32'(done), 32'd1);
            check($sformatf("sweep%0d.quot", k), 32'(quot), 32'(vecs[k].q));
            check($sformatf("sweep%0d.rem", k), 32'(rem), 32'(vecs[k].r));
            check($sformatf("sweep%0d.dbz", k), 32'(div_by_zero), 32'(vecs[k].dz));
            check($sformatf("sweep%0d.busy", k), 32'(busy), (k + 1 < n) ? 32'd1 : 32'd0);
        end
        @(posedge Clk); #1;
        check("sweep.done_one_cycle", 32'(done), 32'd0);

        // Divide by zero, then a normal divide clears the flag
        do_div("div0", 16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 1);
        @(posedge Clk); #1;
        check("div0.done_one_cycle", 32'(done), 32'd0);
        check("div0.hold_dbz", 32'(div_by_zero), 32'd1);
        do_div("d8_2", 16'd8, 16'd2, 16'd4, 16'd0, 1'b0, 17);

        // start and operand changes during RUN are ignored; outputs hold mid-RUN
        a = 16'd40; b = 16'd3; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("ign.mid_busy", 32'(busy), 32'd1);
        check("ign.mid_quot_hold", 32'(quot), 32'd4);
        start = 1'b1; a = 16'd1; b = 16'd1;
        @(posedge Clk); #1;
        start = 1'b0; a = 16'd77; b = 16'd99;
        wait_done(lat);
        check("ign.latency", 32'(lat), 32'd12);
        check("ign.quot", 32'(quot), 32'd13);
        check("ign.rem", 32'(rem), 32'd1);

        // Asynchronous reset mid-RUN discards the divide
        a = 16'd1000; b = 16'd10; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (7) @(posedge Clk);
        #3;
        Rst = 1'b0;
        #1;
        check("arst.busy", 32'(busy), 32'd0);
        check("arst.done", 32'(done), 32'd0);
        check("arst.quot", 32'(quot), 32'd0);
        check("arst.rem", 32'(rem), 32'd0);
        check("arst.dbz", 32'(div_by_zero), 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("arst.no_done", 32'(done), 32'd0);
        do_div("post_rst", 16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
